// File: rtl/globals.sv
// Shared ALU datapath constants: word length, ALU op codes and destination selects.
package globals;

  localparam int unsigned WORDLEN = 16;

  localparam logic [3:0] ALU_CLR  = 4'd0;   // q = 0
  localparam logic [3:0] ALU_SET  = 4'd1;   // q = all ones
  localparam logic [3:0] ALU_PASS = 4'd2;   // q = sbus
  localparam logic [3:0] ALU_NOT  = 4'd3;   // q = ~sbus
  localparam logic [3:0] ALU_INCS = 4'd4;   // q = sbus + 1
  localparam logic [3:0] ALU_ACC  = 4'd5;   // q = acc
  localparam logic [3:0] ALU_ADD  = 4'd6;   // q = acc + sbus
  localparam logic [3:0] ALU_SUBA = 4'd7;   // q = acc - sbus
  localparam logic [3:0] ALU_SUBS = 4'd8;   // q = sbus - acc
  localparam logic [3:0] ALU_AND  = 4'd9;   // q = acc & sbus
  localparam logic [3:0] ALU_OR   = 4'd10;  // q = acc | sbus
  localparam logic [3:0] ALU_INCA = 4'd11;  // q = acc + 1

  localparam logic [3:0] DST_ACC  = 4'd1;   // acc <= shift at the clock edge

endpackage

// File: rtl/alu_req_sequencer_if.sv
// Request/response bundle between the two ALU clients and the sequencer.
interface alu_req_sequencer_if;

  logic [1:0]                   req_valid;
  logic [1:0]                   req_ready;
  logic [3:0]                   req_op0;
  logic [globals::WORDLEN-1:0]  req_a0;
  logic [globals::WORDLEN-1:0]  req_b0;
  logic [3:0]                   req_op1;
  logic [globals::WORDLEN-1:0]  req_a1;
  logic [globals::WORDLEN-1:0]  req_b1;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic                         rsp_id;
  logic [globals::WORDLEN-1:0]  rsp_data;

  // Client side
  modport master (
    output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_req_sequencer.sv
// Round-robin sequencer sharing one ALU between two requesters: optional acc load,
// one execute cycle, then a held response until the consumer takes it.
module alu_req_sequencer #(
  parameter logic [3:0] DST_NOP = 4'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  alu_req_sequencer_if.slave          req_if,
  output logic [3:0]                  ctl_dest_o,
  output logic [3:0]                  ctl_alu_o,
  output logic [globals::WORDLEN-1:0] sbus_o,
  output logic [globals::WORDLEN-1:0] shift_o,
  input  logic [globals::WORDLEN-1:0] q_i
);

  localparam int unsigned W = globals::WORDLEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         rr_q, rr_d;
  logic         id_q, id_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]   ctl_dest_q, ctl_dest_d;
  logic [3:0]   ctl_alu_q, ctl_alu_d;
  logic [W-1:0] sbus_q, sbus_d;
  logic [W-1:0] shift_q, shift_d;
  logic [1:0]   grant;

  // Ops that read the accumulator need operand a loaded first
  function automatic logic needs_acc(input logic [3:0] op);
    case (op)
      globals::ALU_ACC, globals::ALU_ADD, globals::ALU_SUBA, globals::ALU_SUBS,
      globals::ALU_AND, globals::ALU_OR,  globals::ALU_INCA: needs_acc = 1'b1;
      default:                                               needs_acc = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    grant      = 2'b00;

    if (state_q == IDLE && !rst) begin
      grant[0] = req_if.req_valid[0] & (~req_if.req_valid[1] | ~rr_q);
      grant[1] = req_if.req_valid[1] & (~req_if.req_valid[0] |  rr_q);
    end

    case (state_q)
      IDLE: begin
        if (|grant) begin
          id_d    = grant[1];
          op_d    = grant[1] ? req_if.req_op1 : req_if.req_op0;
          a_d     = grant[1] ? req_if.req_a1  : req_if.req_a0;
          b_d     = grant[1] ? req_if.req_b1  : req_if.req_b0;
          rr_d    = ~grant[1];
          state_d = needs_acc(op_d) ? LOAD : EXEC;
        end
      end
      LOAD: state_d = EXEC;
      EXEC: begin
        rsp_data_d = q_i;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: if (req_if.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Control outputs are registered, so they are derived from the state being entered
    ctl_dest_d  = (state_d == LOAD) ? globals::DST_ACC : DST_NOP;
    shift_d     = (state_d == LOAD) ? a_d : '0;
    ctl_alu_d   = (state_d == EXEC) ? op_d : globals::ALU_CLR;
    sbus_d      = (state_d == EXEC) ? b_d : '0;
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      ctl_dest_q  <= DST_NOP;
      ctl_alu_q   <= globals::ALU_CLR;
      sbus_q      <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      ctl_dest_q  <= ctl_dest_d;
      ctl_alu_q   <= ctl_alu_d;
      sbus_q      <= sbus_d;
      shift_q     <= shift_d;
    end
  end

  assign req_if.req_ready = grant;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_id    = rsp_id_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign ctl_dest_o       = ctl_dest_q;
  assign ctl_alu_o        = ctl_alu_q;
  assign sbus_o           = sbus_q;
  assign shift_o          = shift_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Bench for alu_req_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_req_sequencer;
  import globals::*;

  localparam int unsigned W = WORDLEN;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   ctl_dest;
  logic [3:0]   ctl_alu;
  logic [W-1:0] sbus;
  logic [W-1:0] shift;
  logic [W-1:0] q;
  logic [W-1:0] acc = '0;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_req_sequencer_if bus ();

  alu_req_sequencer #(.DST_NOP(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus),
    .ctl_dest_o (ctl_dest),
    .ctl_alu_o  (ctl_alu),
    .sbus_o     (sbus),
    .shift_o    (shift),
    .q_i        (q)
  );

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] acc_v,
                                          input logic [W-1:0] s);
    case (op)
      ALU_CLR:  alu_fn = '0;
      ALU_SET:  alu_fn = '1;
      ALU_PASS: alu_fn = s;
      ALU_NOT:  alu_fn = ~s;
      ALU_INCS: alu_fn = s + W'(1);
      ALU_ACC:  alu_fn = acc_v;
      ALU_ADD:  alu_fn = acc_v + s;
      ALU_SUBA: alu_fn = acc_v - s;
      ALU_SUBS: alu_fn = s - acc_v;
      ALU_AND:  alu_fn = acc_v & s;
      ALU_OR:   alu_fn = acc_v | s;
      ALU_INCA: alu_fn = acc_v + W'(1);
      default:  alu_fn = '0;
    endcase
  endfunction

  // Behavioural ALU: acc is never reset
  always @(posedge clk) if (ctl_dest == DST_ACC) acc <= shift;
  always_comb q = alu_fn(ctl_alu, acc, sbus);

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", bus.rsp_id, bus.rsp_data);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_data} !== {e.id, e.data}) begin
          n_fail++;
          $display("FAIL rsp_data: got id=%0d data=%h, required id=%0d data=%h",
                   bus.rsp_id, bus.rsp_data, e.id, e.data);
        end
      end
    end
  end

  task automatic send(input int idx, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp, output bit ok);
    if (idx == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
    else          begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_valid[idx] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.req_ready[idx]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      sb.push_back('{id: 1'(idx), data: exp});
      @(posedge clk);
      @(negedge clk);
    end else begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: requester %0d got no req_ready, required a grant", idx);
    end
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !bus.rsp_valid) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got ready=%b rsp_valid=%b, required 00/0", bus.req_ready, bus.rsp_valid);
    end
    n_tests++;
    if ({bus.rsp_id, bus.rsp_data, ctl_dest, ctl_alu, sbus, shift} !== {1'b0, W'(0), 4'd0, ALU_CLR, W'(0), W'(0)}) begin
      n_fail++;
      $display("FAIL reset_outputs: got id=%0d data=%h dest=%h alu=%h sbus=%h shift=%h, required all idle",
               bus.rsp_id, bus.rsp_data, ctl_dest, ctl_alu, sbus, shift);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_latency();
    bit ok;
    bus.rsp_ready = 1'b1;
    send(0, ALU_ADD, W'(5), W'(3), W'(8), ok);
    if (ok) begin
      n_tests++;
      if (ctl_dest !== DST_ACC || shift !== W'(5)) begin
        n_fail++;
        $display("FAIL load_cycle: got dest=%h shift=%h, required %h/0005", ctl_dest, shift, DST_ACC);
      end
      @(negedge clk);
      n_tests++;
      if (ctl_dest !== 4'd0 || ctl_alu !== ALU_ADD || sbus !== W'(3) || bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL exec_cycle: got dest=%h alu=%h sbus=%h rv=%b, required 0/%h/0003/0",
                 ctl_dest, ctl_alu, sbus, bus.rsp_valid, ALU_ADD);
      end
      @(negedge clk);
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || ctl_dest !== 4'd0) begin
        n_fail++;
        $display("FAIL add_latency: got rsp_valid=%b dest=%h at k+3, required 1/0", bus.rsp_valid, ctl_dest);
      end
      @(negedge clk);
      n_tests++;
      if (bus.rsp_valid !== 1'b0 || ctl_alu !== ALU_CLR) begin
        n_fail++;
        $display("FAIL back_to_idle: got rsp_valid=%b alu=%h at k+4, required 0/%h", bus.rsp_valid, ctl_alu, ALU_CLR);
      end
    end
    wait_drain();
  endtask

  task automatic test_sub();
    bit ok;
    send(1, ALU_SUBA, W'(2), W'(9), W'(2**W - 7), ok);
    wait_drain();
    send(1, ALU_SUBS, W'(2), W'(9), W'(7), ok);
    wait_drain();
  endtask

  task automatic test_round_robin();
    logic exp_g = 1'b0;
    int   grants = 0;
    rst = 1'b1;
    bus.req_op0 = ALU_ADD;  bus.req_a0 = W'(16'h0100); bus.req_b0 = W'(16'h0011);
    bus.req_op1 = ALU_INCA; bus.req_a1 = W'(16'h0200); bus.req_b1 = W'(16'h0022);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 200 && grants < 8; c++) begin
      #1;
      if (bus.req_ready !== 2'b00) begin
        n_tests++;
        if (bus.req_ready !== (exp_g ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_grant: got req_ready=%b at grant %0d, required %b",
                   bus.req_ready, grants, exp_g ? 2'b10 : 2'b01);
        end
        if (!exp_g) sb.push_back('{id: 1'b0, data: alu_fn(bus.req_op0, bus.req_a0, bus.req_b0)});
        else        sb.push_back('{id: 1'b1, data: alu_fn(bus.req_op1, bus.req_a1, bus.req_b1)});
        @(negedge clk);
        if (!exp_g) begin
          bus.req_op0 = $urandom_range(0, 1) ? ALU_ADD : ALU_INCA;
          bus.req_a0  = W'($urandom); bus.req_b0 = W'($urandom);
        end else begin
          bus.req_op1 = $urandom_range(0, 1) ? ALU_ADD : ALU_INCA;
          bus.req_a1  = W'($urandom); bus.req_b1 = W'($urandom);
        end
        exp_g = ~exp_g;
        grants++;
      end else begin
        @(negedge clk);
      end
    end
    bus.req_valid = 2'b00;
    n_tests++;
    if (grants != 8) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants, required 8", grants);
    end
    wait_drain();
  endtask

  task automatic test_pass_no_load();
    bit ok;
    send(0, ALU_ACC, W'(16'h1234), W'(0), W'(16'h1234), ok);
    wait_drain();
    send(0, ALU_PASS, W'(16'hBEEF), W'(16'h005A), W'(16'h005A), ok);
    if (ok) begin
      n_tests++;
      if (ctl_dest !== 4'd0 || ctl_alu !== ALU_PASS || sbus !== W'(16'h005A)) begin
        n_fail++;
        $display("FAIL pass_no_load: got dest=%h alu=%h sbus=%h at k+1, required 0/%h/005a",
                 ctl_dest, ctl_alu, sbus, ALU_PASS);
      end
      @(negedge clk);
      n_tests++;
      if (bus.rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL pass_latency: got rsp_valid=%b at k+2, required 1", bus.rsp_valid);
      end
    end
    wait_drain();
    n_tests++;
    if (acc !== W'(16'h1234)) begin
      n_fail++;
      $display("FAIL acc_untouched: got acc=%h, required 1234", acc);
    end
    send(0, ALU_ACC, W'(16'h0077), W'(0), W'(16'h0077), ok);
    wait_drain();
    send(1, 4'hE, W'(3), W'(4), W'(0), ok);
    wait_drain();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen = 1'b0;
    bus.rsp_ready = 1'b0;
    send(0, ALU_ADD, W'(1), W'(2), W'(3), ok);
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_timeout: rsp_valid never rose, required 1");
    end
    bus.req_op1 = ALU_OR; bus.req_a1 = W'(16'h000C); bus.req_b1 = W'(16'h0003);
    bus.req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== W'(3) || bus.rsp_id !== 1'b0 || bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold: got rv=%b data=%h id=%0d ready=%b, required 1/0003/0/00",
                 bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.req_ready !== 2'b10 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ready=%b rv=%b after handshake, required 10/0", bus.req_ready, bus.rsp_valid);
    end else begin
      sb.push_back('{id: 1'b1, data: W'(16'h000F)});
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_t dropped;
    bus.rsp_ready = 1'b1;
    send(0, ALU_ADD, W'(10), W'(20), W'(30), ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (ok) dropped = sb.pop_back();
    n_tests++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b00, 1'b0, 1'b0, W'(0)} ||
        {ctl_dest, ctl_alu, sbus, shift} !== {4'd0, ALU_CLR, W'(0), W'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid: got ready=%b rv=%b id=%0d data=%h dest=%h alu=%h sbus=%h shift=%h, required reset values",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, ctl_dest, ctl_alu, sbus, shift);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: got rsp_valid=%b after reset, required 0", bus.rsp_valid);
    end
    send(1, ALU_OR, W'(16'h00F0), W'(16'h000F), W'(16'h00FF), ok);
    wait_drain();
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_op0 = 4'd0; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = 4'd0; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add_latency();
    test_sub();
    test_round_robin();
    test_pass_no_load();
    test_backpressure();
    test_reset_mid();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
